// File: rtl/imm_ext_unit.sv
// imm_ext_unit: immediate widening unit for the ID stage.
// Converts IMM_W-bit immediates to DATA_W bits in one of four modes.
// Results are buffered in a 2-entry FIFO behind valid/ready handshakes.
// in_ready depends only on registered state, so no combinational path
// runs from the output handshake back to the input.
module imm_ext_unit #(
    parameter int unsigned IMM_W  = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SHAMT  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_out,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        MODE_SEXT   = 2'b00,
        MODE_ZEXT   = 2'b01,
        MODE_LUI    = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_e;

    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic              head_q, head_d;
    logic [1:0]        count_q, count_d;

    logic [DATA_W-1:0] sext_v;
    logic [DATA_W-1:0] zext_v;
    logic [DATA_W-1:0] ext_v;
    logic              push;
    logic              pop;
    logic              tail;

    // Widen the incoming immediate according to the requested mode.
    always_comb begin
        sext_v = DATA_W'($signed(imm_in));
        zext_v = DATA_W'(imm_in);
        case (mode_e'(mode))
            MODE_SEXT:   ext_v = sext_v;
            MODE_ZEXT:   ext_v = zext_v;
            // Shift form also covers DATA_W == IMM_W without a zero-width replicate.
            MODE_LUI:    ext_v = zext_v << (DATA_W - IMM_W);
            MODE_BRANCH: ext_v = sext_v << SHAMT;
            default:     ext_v = sext_v;
        endcase
    end

    // Handshake decode and registered-state outputs.
    always_comb begin
        in_ready  = (count_q != 2'd2);
        out_valid = (count_q != 2'd0);
        count     = count_q;
        imm_out   = out_valid ? data_q[head_q] : '0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        // Tail slot is the head when empty, the other slot when holding one entry.
        tail      = head_q ^ count_q[0];
    end

    // Next-state for FIFO storage, head pointer and occupancy; flush wins over push/pop.
    always_comb begin
        data_d[0] = data_q[0];
        data_d[1] = data_q[1];
        head_d    = head_q;
        count_d   = count_q;
        if (flush) begin
            head_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push) begin
                data_d[tail] = ext_v;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q[0] <= '0;
            data_q[1] <= '0;
            head_q    <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            data_q[0] <= data_d[0];
            data_q[1] <= data_d[1];
            head_q    <= head_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_imm_ext_unit.sv
// tb_imm_ext_unit: table vectors, hand-written corner sequences and random
// traffic checked against a queue-based reference model.
module tb_imm_ext_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm_in;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] imm_out;
    logic [1:0]  count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [11:0] s_imm_in;
    logic [1:0]  s_mode;
    logic        s_out_valid;
    logic [31:0] s_imm_out;
    logic [1:0]  s_count;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] mq[$];
    bit          model_known = 1'b0;

    imm_ext_unit #(.IMM_W(16), .DATA_W(32), .SHAMT(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .imm_in(imm_in), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm_out(imm_out), .count(count)
    );

    imm_ext_unit #(.IMM_W(12), .DATA_W(32), .SHAMT(1)) dut_s (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .imm_in(s_imm_in), .mode(s_mode),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .imm_out(s_imm_out), .count(s_count)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: interpret the immediate as an integer, then scale.
    function automatic logic [31:0] ref_ext(input logic [31:0] imm, input logic [1:0] m,
                                            input int iw, input int dw, input int sh);
        longint v, s, r;
        v = longint'(imm) & ((longint'(1) << iw) - 1);
        s = (v >= (longint'(1) << (iw - 1))) ? v - (longint'(1) << iw) : v;
        case (m)
            2'd0:    r = s;
            2'd1:    r = v;
            2'd2:    r = v * (longint'(1) << (dw - iw));
            default: r = s * (longint'(1) << sh);
        endcase
        return 32'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check in_ready, advance the model with the current inputs, check outputs.
    task automatic cyc();
        bit do_push, do_pop;
        if (model_known) chk("in_ready", 32'(in_ready), 32'(mq.size() != 2));
        do_push = in_valid && (mq.size() < 2);
        do_pop  = out_ready && (mq.size() > 0);
        if (rst || flush) begin
            mq.delete();
            if (rst) model_known = 1'b1;
        end else if (model_known) begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(ref_ext(32'(imm_in), mode, 16, 32, 2));
        end
        @(posedge clk);
        #1;
        if (model_known) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
            chk("imm_out", imm_out, (mq.size() != 0) ? mq[0] : 32'h0);
        end
    endtask

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{16'h8000, 2'd0, 32'hFFFF8000};
        tbl[1] = '{16'h7FFF, 2'd0, 32'h00007FFF};
        tbl[2] = '{16'h8000, 2'd1, 32'h00008000};
        tbl[3] = '{16'h1234, 2'd2, 32'h12340000};
        tbl[4] = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
        tbl[5] = '{16'h4001, 2'd3, 32'h00010004};
        tbl[6] = '{16'hFFFF, 2'd1, 32'h0000FFFF};
        tbl[7] = '{16'h8000, 2'd3, 32'hFFFE0000};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; imm_in = '0; mode = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_imm_in = '0; s_mode = '0;
        #1;
        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_imm_out", imm_out, 32'h0);

        // Table vectors, each pushed into an empty FIFO with the consumer ready.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; imm_in = tbl[i].imm; mode = tbl[i].mode;
            cyc();
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_out", imm_out, tbl[i].exp);
            in_valid = 1'b0;
            cyc();
        end

        // Backpressure: A, B, C on consecutive cycles; C is refused.
        out_ready = 1'b0; mode = 2'd1;
        in_valid = 1'b1; imm_in = 16'h000A; cyc();
        imm_in = 16'h000B; cyc();
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        imm_in = 16'h000C; cyc();
        chk("bp_count", 32'(count), 32'd2);
        chk("bp_hold", imm_out, 32'h0000000A);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("bp_second", imm_out, 32'h0000000B);
        chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
        cyc();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // count==1 with simultaneous push and pop.
        out_ready = 1'b0; in_valid = 1'b1; imm_in = 16'h0011; cyc();
        out_ready = 1'b1; imm_in = 16'h0022; cyc();
        chk("pp_count", 32'(count), 32'd1);
        chk("pp_out", imm_out, 32'h00000022);
        in_valid = 1'b0; cyc();

        // Flush with count==2 and a push presented in the same cycle.
        out_ready = 1'b0; in_valid = 1'b1; imm_in = 16'h0033; cyc();
        imm_in = 16'h0044; cyc();
        flush = 1'b1; imm_in = 16'h0055; out_ready = 1'b1; cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_imm_out", imm_out, 32'h0);
        cyc();
        chk("flush_lost", 32'(out_valid), 32'd0);

        // Reset mid-stream with count==2.
        out_ready = 1'b0; in_valid = 1'b1; imm_in = 16'h0066; cyc();
        imm_in = 16'h0077; cyc();
        rst = 1'b1; in_valid = 1'b0; cyc();
        rst = 1'b0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_imm_out", imm_out, 32'h0);

        // Alternate parameter set: IMM_W=12, SHAMT=1.
        s_in_valid = 1'b1; s_imm_in = 12'h800; s_mode = 2'd0; cyc();
        chk("s_sext", s_imm_out, 32'hFFFFF800);
        chk("s_sext_model", s_imm_out, ref_ext(32'h800, 2'd0, 12, 32, 1));
        s_mode = 2'd3; cyc();
        chk("s_branch", s_imm_out, 32'hFFFFF000);
        s_mode = 2'd2; s_imm_in = 12'hABC; cyc();
        chk("s_lui", s_imm_out, ref_ext(32'hABC, 2'd2, 12, 32, 1));
        s_in_valid = 1'b0; cyc();
        chk("s_empty", 32'(s_out_valid), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            imm_in    = 16'($urandom);
            mode      = 2'($urandom_range(0, 3));
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 79) == 0);
            cyc();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
